// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: core has fixed priority, debug is forced in after MAX_HOLD
// consecutive contested core grants. Read data (1-cycle latency) is routed to its issuer.
module dm_port_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              core_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   typedef enum logic [1:0] {IDLE, CORE, DBG} owner_t;

   owner_t           last_owner, owner_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic             rd_pend, rd_pend_nxt;
   logic             hold_full;

   always_ff @(posedge clk) begin
      if (rstn) begin
         last_owner <= IDLE;
         hold_cnt   <= '0;
         rd_pend    <= 1'b0;
      end else begin
         last_owner <= owner_nxt;
         hold_cnt   <= hold_nxt;
         rd_pend    <= rd_pend_nxt;
      end
   end

   always_comb begin
      hold_full   = (hold_cnt == CNT_W'(MAX_HOLD));
      c_gnt       = 1'b0;
      d_gnt       = 1'b0;
      if (!rstn) begin
         c_gnt = c_req & (~d_req | ~hold_full);
         d_gnt = d_req & ~c_gnt;
      end
      core_stall  = c_req & ~c_gnt;

      m_en        = c_gnt | d_gnt;
      m_we        = 1'b0;
      m_addr      = '0;
      m_wdata     = '0;
      if (c_gnt) begin
         m_we    = c_we;
         m_addr  = c_addr;
         m_wdata = c_wdata;
      end else if (d_gnt) begin
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end

      owner_nxt   = IDLE;
      if (c_gnt)      owner_nxt = CORE;
      else if (d_gnt) owner_nxt = DBG;

      // Count only contested core wins; any debug win or idle core restarts the window.
      hold_nxt    = hold_cnt;
      if (d_gnt || !c_req)                    hold_nxt = '0;
      else if (c_gnt && d_req && !hold_full)  hold_nxt = hold_cnt + CNT_W'(1);

      rd_pend_nxt = m_en & ~m_we;
   end

   // last_owner doubles as the read tag: it names the issuer of last cycle's access.
   always_comb begin
      c_rvalid = ~rstn & rd_pend & (last_owner == CORE);
      d_rvalid = ~rstn & rd_pend & (last_owner == DBG);
      c_rdata  = c_rvalid ? m_rdata : '0;
      d_rdata  = d_rvalid ? m_rdata : '0;
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: vector table plus hand sequences for hold/reset cases.
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
   logic [15:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
   logic        c_gnt, c_rvalid, core_stall, d_gnt, d_rvalid, m_en, m_we;
   logic [15:0] c_rdata, d_rdata, m_addr, m_wdata;
   logic [15:0] m_rdata = 0;
   // second instance, MAX_HOLD=1
   logic        a_c_gnt, a_c_rvalid, a_core_stall, a_d_gnt, a_d_rvalid, a_m_en, a_m_we;
   logic [15:0] a_c_rdata, a_d_rdata, a_m_addr, a_m_wdata;
   logic [15:0] zero16 = 16'h0;
   logic [15:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dm_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(4), .CNT_W(3)) dut (
      .clk(clk), .rstn(rstn),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata));

   dm_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(1), .CNT_W(2)) dut1 (
      .clk(clk), .rstn(rstn),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(a_c_gnt), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata), .core_stall(a_core_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
      .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(zero16));

   // Memory model: preloaded under reset, 1-cycle read latency.
   always @(posedge clk) begin
      if (rstn) begin
         mem[8'h10] <= 16'hBEEF;
         mem[8'h01] <= 16'h1111;
         mem[8'h02] <= 16'h2222;
         mem[8'h20] <= 16'h0000;
      end else if (m_en) begin
         if (m_we) mem[m_addr[7:0]] <= m_wdata;
         else      m_rdata <= mem[m_addr[7:0]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic cr, input logic cw, input logic [15:0] ca,
                        input logic [15:0] cd, input logic dr, input logic dw,
                        input logic [15:0] da, input logic [15:0] dd);
      @(posedge clk);
      #1;
      rstn = rst; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
      @(negedge clk);
   endtask

   typedef struct {
      logic        rst, cr, cw;
      logic [15:0] ca, cd;
      logic        dr, dw;
      logic [15:0] da, dd;
      logic        e_cg, e_dg, e_st, e_men, e_mwe;
      logic [15:0] e_maddr, e_mwd;
      logic        e_crv;
      logic [15:0] e_crd;
      logic        e_drv;
      logic [15:0] e_drd;
   } vec_t;

   vec_t vt [9];

   initial begin
      //        rst cr cw ca      cd       dr dw da      dd       cg dg st men mwe maddr  mwd      crv crd      drv drd
      vt[0] = '{1, 1, 0, 16'h10, 16'h0,   0, 0, 16'h0,  16'h0,   0, 0, 1, 0, 0, 16'h0,  16'h0,   0, 16'h0,   0, 16'h0};
      vt[1] = '{0, 1, 0, 16'h10, 16'h0,   0, 0, 16'h0,  16'h0,   1, 0, 0, 1, 0, 16'h10, 16'h0,   0, 16'h0,   0, 16'h0};
      vt[2] = '{0, 0, 0, 16'h0,  16'h0,   0, 0, 16'h0,  16'h0,   0, 0, 0, 0, 0, 16'h0,  16'h0,   1, 16'hBEEF,0, 16'h0};
      vt[3] = '{0, 0, 0, 16'h0,  16'h0,   1, 1, 16'h20, 16'h1234,0, 1, 0, 1, 1, 16'h20, 16'h1234,0, 16'h0,   0, 16'h0};
      vt[4] = '{0, 1, 0, 16'h20, 16'h0,   0, 0, 16'h0,  16'h0,   1, 0, 0, 1, 0, 16'h20, 16'h0,   0, 16'h0,   0, 16'h0};
      vt[5] = '{0, 0, 0, 16'h0,  16'h0,   0, 0, 16'h0,  16'h0,   0, 0, 0, 0, 0, 16'h0,  16'h0,   1, 16'h1234,0, 16'h0};
      vt[6] = '{0, 1, 0, 16'h01, 16'h0,   0, 0, 16'h0,  16'h0,   1, 0, 0, 1, 0, 16'h01, 16'h0,   0, 16'h0,   0, 16'h0};
      vt[7] = '{0, 0, 0, 16'h0,  16'h0,   1, 0, 16'h02, 16'h0,   0, 1, 0, 1, 0, 16'h02, 16'h0,   1, 16'h1111,0, 16'h0};
      vt[8] = '{0, 0, 0, 16'h0,  16'h0,   0, 0, 16'h0,  16'h0,   0, 0, 0, 0, 0, 16'h0,  16'h0,   0, 16'h0,   1, 16'h2222};

      repeat (3) @(posedge clk);

      for (int i = 0; i < 9; i++) begin
         drive(vt[i].rst, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd,
               vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd);
         check($sformatf("v%0d c_gnt", i),      c_gnt,      vt[i].e_cg);
         check($sformatf("v%0d d_gnt", i),      d_gnt,      vt[i].e_dg);
         check($sformatf("v%0d core_stall", i), core_stall, vt[i].e_st);
         check($sformatf("v%0d m_en", i),       m_en,       vt[i].e_men);
         check($sformatf("v%0d m_we", i),       m_we,       vt[i].e_mwe);
         check($sformatf("v%0d m_addr", i),     m_addr,     vt[i].e_maddr);
         check($sformatf("v%0d m_wdata", i),    m_wdata,    vt[i].e_mwd);
         check($sformatf("v%0d c_rvalid", i),   c_rvalid,   vt[i].e_crv);
         check($sformatf("v%0d c_rdata", i),    c_rdata,    vt[i].e_crd);
         check($sformatf("v%0d d_rvalid", i),   d_rvalid,   vt[i].e_drv);
         check($sformatf("v%0d d_rdata", i),    d_rdata,    vt[i].e_drd);
      end

      // Contention: MAX_HOLD=4 gives C,C,C,C,D repeating; MAX_HOLD=1 strictly alternates.
      for (int k = 0; k < 10; k++) begin
         drive(0, 1, 1, 16'h40, 16'hAAAA, 1, 1, 16'h41, 16'h5555);
         check($sformatf("hold4[%0d] c_gnt", k),  c_gnt,      (k % 5) != 4);
         check($sformatf("hold4[%0d] d_gnt", k),  d_gnt,      (k % 5) == 4);
         check($sformatf("hold4[%0d] stall", k),  core_stall, (k % 5) == 4);
         check($sformatf("hold1[%0d] c_gnt", k),  a_c_gnt,    (k % 2) == 0);
         check($sformatf("hold1[%0d] d_gnt", k),  a_d_gnt,    (k % 2) == 1);
         check($sformatf("hold1[%0d] m_wdata", k), a_m_wdata, ((k % 2) == 0) ? 16'hAAAA : 16'h5555);
      end

      // Read issued, then reset: the pending return must be dropped.
      drive(0, 1, 0, 16'h10, 16'h0, 0, 0, 16'h0, 16'h0);
      check("rst_seq issue c_gnt", c_gnt, 1'b1);
      drive(1, 1, 0, 16'h10, 16'h0, 1, 0, 16'h02, 16'h0);
      check("rst_seq c_rvalid", c_rvalid, 1'b0);
      check("rst_seq c_rdata",  c_rdata,  16'h0);
      check("rst_seq c_gnt",    c_gnt,    1'b0);
      check("rst_seq d_gnt",    d_gnt,    1'b0);
      check("rst_seq m_en",     m_en,     1'b0);
      check("rst_seq stall",    core_stall, 1'b1);
      drive(0, 1, 0, 16'h10, 16'h0, 1, 0, 16'h02, 16'h0);
      check("post_rst c_gnt",    c_gnt,    1'b1);
      check("post_rst d_gnt",    d_gnt,    1'b0);
      check("post_rst c_rvalid", c_rvalid, 1'b0);
      check("post_rst d_rvalid", d_rvalid, 1'b0);
      drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h02, 16'h0);
      check("post_rst2 d_gnt",    d_gnt,    1'b1);
      check("post_rst2 c_rvalid", c_rvalid, 1'b1);
      check("post_rst2 c_rdata",  c_rdata,  16'hBEEF);
      drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      check("post_rst3 d_rvalid", d_rvalid, 1'b1);
      check("post_rst3 d_rdata",  d_rdata,  16'h2222);
      check("post_rst3 c_rvalid", c_rvalid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
